pipe_ctrl: RTL and testbench

Central pipeline controller for the five-stage miniRV core. Generates the enable/flush controls for the IF_ID, ID_EX, EX_MEM and MEM_WB pipeline registers and the PC. Detects load-use hazards, branch/jump redirects and multi-cycle DRAM accesses, and selects EX-stage operand forwarding. Sits beside the datapath. Its only state is a DRAM-wait FSM, a timeout counter and two saturating performance counters.

---
 rtl/pipe_ctrl_pkg.sv | 45 ++++
 rtl/pipe_ctrl_if.sv | 74 +++++++
 rtl/pipe_ctrl_fwd_unit.sv | 26 ++
 rtl/pipe_ctrl.sv | 159 +++++++++++++++
 tb/tb_pipe_ctrl.sv | 309 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the miniRV pipeline controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pipe_ctrl_pkg;

    typedef logic [4:0] reg_idx_t;
    typedef logic [1:0] fwd_sel_t;

    // EX operand source selects
    localparam fwd_sel_t FWD_RF  = 2'b00;
    localparam fwd_sel_t FWD_MEM = 2'b01;
    localparam fwd_sel_t FWD_WB  = 2'b10;

    // DRAM-wait FSM encodings
    localparam logic [0:0] ST_RUN  = 1'b0;
    localparam logic [0:0] ST_WAIT = 1'b1;

    // Pipeline register controls, grouped so each hazard case is one constant
    typedef struct packed {
        logic pc_en;
        logic if_id_en;
        logic id_ex_en;
        logic ex_mem_en;
        logic mem_wb_en;
        logic if_id_flush;
        logic id_ex_flush;
        logic mem_wb_flush;
    } ctrl_t;

    // Free-running pipeline
    localparam ctrl_t CTRL_RUN   = ctrl_t'(8'b11111_000);
    // DRAM stall: everything up to EX/MEM holds, a bubble drains into WB
    localparam ctrl_t CTRL_MEM   = ctrl_t'(8'b00001_001);
    // Redirect: squash the two younger instructions, keep moving
    localparam ctrl_t CTRL_REDIR = ctrl_t'(8'b11111_110);
    // Load-use: hold PC and IF/ID, inject one bubble into EX
    localparam ctrl_t CTRL_LU    = ctrl_t'(8'b00111_010);

    // A producer forwards to a consumer only when it really writes a
    // non-x0 register that the consumer names.
    function automatic logic dst_hit(input logic we, input reg_idx_t dst, input reg_idx_t src);
        return we && (dst != '0) && (dst == src);
    endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// Bundle between the miniRV datapath and the pipeline controller.
// Latency: n/a (wires only).
// Backpressure: n/a; stalls are expressed through the enable/flush outputs.
// Ports: master = datapath (drives hazard info, receives controls),
//        slave  = pipe_ctrl (the reverse).
interface pipe_ctrl_if
    import pipe_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) ();

    // ID stage sources
    reg_idx_t id_rs1;
    reg_idx_t id_rs2;
    logic     id_rs1_used;
    logic     id_rs2_used;
    // EX stage
    reg_idx_t ex_rs1;
    reg_idx_t ex_rs2;
    reg_idx_t ex_wR;
    logic     ex_rf_we;
    logic     ex_is_load;
    logic     ex_redirect;
    // MEM / WB destinations
    reg_idx_t mem_wR;
    logic     mem_rf_we;
    reg_idx_t wb_wR;
    logic     wb_rf_we;
    // DRAM handshake
    logic     mem_req;
    logic     dram_ready;
    logic     dram_req;
    // Pipeline register controls
    logic     pc_en;
    logic     if_id_en;
    logic     id_ex_en;
    logic     ex_mem_en;
    logic     mem_wb_en;
    logic     if_id_flush;
    logic     id_ex_flush;
    logic     mem_wb_flush;
    // Forwarding selects
    fwd_sel_t fwd_rs1_sel;
    fwd_sel_t fwd_rs2_sel;
    // Status
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;
    logic             timeout_err;

    modport master (
        output id_rs1, id_rs2, id_rs1_used, id_rs2_used,
        output ex_rs1, ex_rs2, ex_wR, ex_rf_we, ex_is_load, ex_redirect,
        output mem_wR, mem_rf_we, wb_wR, wb_rf_we,
        output mem_req, dram_ready,
        input  dram_req,
        input  pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
        input  if_id_flush, id_ex_flush, mem_wb_flush,
        input  fwd_rs1_sel, fwd_rs2_sel,
        input  stall_cnt, flush_cnt, timeout_err
    );

    modport slave (
        input  id_rs1, id_rs2, id_rs1_used, id_rs2_used,
        input  ex_rs1, ex_rs2, ex_wR, ex_rf_we, ex_is_load, ex_redirect,
        input  mem_wR, mem_rf_we, wb_wR, wb_rf_we,
        input  mem_req, dram_ready,
        output dram_req,
        output pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
        output if_id_flush, id_ex_flush, mem_wb_flush,
        output fwd_rs1_sel, fwd_rs2_sel,
        output stall_cnt, flush_cnt, timeout_err
    );

endinterface

// File: rtl/pipe_ctrl_fwd_unit.sv
// Operand forwarding select for one EX source register.
// Latency: combinational, zero cycles.
// Backpressure: none.
// Ports: ex_rs_i source; mem_*/wb_* producer destinations; sel_o 00 RF, 01 MEM, 10 WB.
module fwd_unit
    import pipe_ctrl_pkg::*;
(
    input  reg_idx_t ex_rs_i,
    input  logic     mem_rf_we_i,
    input  reg_idx_t mem_wr_i,
    input  logic     wb_rf_we_i,
    input  reg_idx_t wb_wr_i,
    output fwd_sel_t sel_o
);

    // MEM holds the younger result, so it overrides WB.
    always_comb begin
        sel_o = FWD_RF;
        if (dst_hit(mem_rf_we_i, mem_wr_i, ex_rs_i)) begin
            sel_o = FWD_MEM;
        end else if (dst_hit(wb_rf_we_i, wb_wr_i, ex_rs_i)) begin
            sel_o = FWD_WB;
        end
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Central hazard/stall/flush/forwarding controller for the five-stage miniRV core.
// Latency: controls and forwarding are combinational (zero cycles); counters and
//          timeout_err update on the edge after the qualifying cycle.
// Backpressure: a pending DRAM access freezes PC..EX/MEM until dram_ready or timeout.
// Ports: clk, rst (async, active-low), bus (pipe_ctrl_if.slave).
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int DRAM_TIMEOUT = 15,
    parameter int CNT_W        = 32
) (
    input  logic       clk,
    input  logic       rst,
    pipe_ctrl_if.slave bus
);

    localparam int WC_W = (DRAM_TIMEOUT > 1) ? $clog2(DRAM_TIMEOUT) : 1;

    logic [0:0]       state_q,     state_d;
    logic [WC_W-1:0]  wait_cnt_q,  wait_cnt_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
    logic             err_q,       err_d;

    logic  mem_stall;
    logic  timeout;
    logic  stall_mem;
    logic  load_use;
    logic  stall_lu;
    logic  redirect_eff;
    ctrl_t ctrl;

    // ------------------------------------------------------------------
    // Hazard detection
    // ------------------------------------------------------------------
    assign mem_stall = bus.mem_req && !bus.dram_ready;

    // Last permitted wait cycle: the access is declared done instead of stalling.
    assign timeout   = (state_q == ST_WAIT) &&
                       (wait_cnt_q == WC_W'(DRAM_TIMEOUT - 1)) &&
                       !bus.dram_ready;

    assign stall_mem = mem_stall && !timeout;

    assign load_use  = bus.ex_is_load &&
                       (dst_hit(bus.ex_rf_we, bus.ex_wR, bus.id_rs1) && bus.id_rs1_used ||
                        dst_hit(bus.ex_rf_we, bus.ex_wR, bus.id_rs2) && bus.id_rs2_used);

    // Priority: DRAM stall > redirect > load-use. A frozen EX re-presents its
    // redirect next cycle; a redirect squashes the ID instruction that would
    // otherwise cause the load-use stall.
    always_comb begin
        ctrl         = CTRL_RUN;
        stall_lu     = 1'b0;
        redirect_eff = 1'b0;
        if (stall_mem) begin
            ctrl = CTRL_MEM;
        end else if (bus.ex_redirect) begin
            ctrl         = CTRL_REDIR;
            redirect_eff = 1'b1;
        end else if (load_use) begin
            ctrl     = CTRL_LU;
            stall_lu = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // DRAM wait FSM and sticky timeout flag
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        err_d      = err_q | timeout;
        case (state_q)
            ST_RUN: begin
                if (mem_stall) begin
                    state_d    = ST_WAIT;
                    wait_cnt_d = '0;
                end
            end
            ST_WAIT: begin
                if (bus.dram_ready || timeout) begin
                    state_d = ST_RUN;
                end else begin
                    wait_cnt_d = wait_cnt_q + WC_W'(1);
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    // ------------------------------------------------------------------
    // Saturating performance counters
    // ------------------------------------------------------------------
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if ((stall_mem || stall_lu) && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        if (redirect_eff && (flush_cnt_q != '1)) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_RUN;
            wait_cnt_q  <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
            err_q       <= err_d;
        end
    end

    // ------------------------------------------------------------------
    // Forwarding, one unit per EX source
    // ------------------------------------------------------------------
    fwd_unit u_fwd_rs1 (
        .ex_rs_i     (bus.ex_rs1),
        .mem_rf_we_i (bus.mem_rf_we),
        .mem_wr_i    (bus.mem_wR),
        .wb_rf_we_i  (bus.wb_rf_we),
        .wb_wr_i     (bus.wb_wR),
        .sel_o       (bus.fwd_rs1_sel)
    );

    fwd_unit u_fwd_rs2 (
        .ex_rs_i     (bus.ex_rs2),
        .mem_rf_we_i (bus.mem_rf_we),
        .mem_wr_i    (bus.mem_wR),
        .wb_rf_we_i  (bus.wb_rf_we),
        .wb_wr_i     (bus.wb_wR),
        .sel_o       (bus.fwd_rs2_sel)
    );

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.dram_req     = bus.mem_req;
    assign bus.pc_en        = ctrl.pc_en;
    assign bus.if_id_en     = ctrl.if_id_en;
    assign bus.id_ex_en     = ctrl.id_ex_en;
    assign bus.ex_mem_en    = ctrl.ex_mem_en;
    assign bus.mem_wb_en    = ctrl.mem_wb_en;
    assign bus.if_id_flush  = ctrl.if_id_flush;
    assign bus.id_ex_flush  = ctrl.id_ex_flush;
    assign bus.mem_wb_flush = ctrl.mem_wb_flush;
    assign bus.stall_cnt    = stall_cnt_q;
    assign bus.flush_cnt    = flush_cnt_q;
    assign bus.timeout_err  = err_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: vector table, directed multi-cycle
// sequences and a randomized run against a behavioural model.
module tb_pipe_ctrl;
    import pipe_ctrl_pkg::*;

    localparam int TO    = 4;
    localparam int CW    = 8;
    localparam int MAXC  = 255;

    typedef struct packed {
        logic [4:0] id_rs1;
        logic [4:0] id_rs2;
        logic       id_rs1_used;
        logic       id_rs2_used;
        logic [4:0] ex_rs1;
        logic [4:0] ex_rs2;
        logic [4:0] ex_wR;
        logic       ex_rf_we;
        logic       ex_is_load;
        logic [4:0] mem_wR;
        logic       mem_rf_we;
        logic [4:0] wb_wR;
        logic       wb_rf_we;
        logic       ex_redirect;
        logic       mem_req;
        logic       dram_ready;
    } in_t;

    typedef struct {
        string       name;
        in_t         in;
        logic [12:0] exp;
    } vec_t;

    // {dram_req, pc, if_id, id_ex, ex_mem, mem_wb en, if_id, id_ex, mem_wb flush, fwd1, fwd2}
    localparam logic [12:0] ALL_RUN = 13'b0_11111_000_00_00;

    logic clk;
    logic rst;
    pipe_ctrl_if #(.CNT_W(CW)) bus ();

    pipe_ctrl #(.DRAM_TIMEOUT(TO), .CNT_W(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    int checks = 0;
    int errors = 0;

    in_t cur;
    // model state
    logic m_wait;
    int   m_waited;
    int   m_stall;
    int   m_flush;
    logic m_err;

    logic [12:0] dut_ctrl;
    assign dut_ctrl = {bus.dram_req, bus.pc_en, bus.if_id_en, bus.id_ex_en, bus.ex_mem_en,
                       bus.mem_wb_en, bus.if_id_flush, bus.id_ex_flush, bus.mem_wb_flush,
                       bus.fwd_rs1_sel, bus.fwd_rs2_sel};

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic apply();
        bus.id_rs1      = cur.id_rs1;
        bus.id_rs2      = cur.id_rs2;
        bus.id_rs1_used = cur.id_rs1_used;
        bus.id_rs2_used = cur.id_rs2_used;
        bus.ex_rs1      = cur.ex_rs1;
        bus.ex_rs2      = cur.ex_rs2;
        bus.ex_wR       = cur.ex_wR;
        bus.ex_rf_we    = cur.ex_rf_we;
        bus.ex_is_load  = cur.ex_is_load;
        bus.mem_wR      = cur.mem_wR;
        bus.mem_rf_we   = cur.mem_rf_we;
        bus.wb_wR       = cur.wb_wR;
        bus.wb_rf_we    = cur.wb_rf_we;
        bus.ex_redirect = cur.ex_redirect;
        bus.mem_req     = cur.mem_req;
        bus.dram_ready  = cur.dram_ready;
    endtask

    // ---------------- behavioural model ----------------
    function automatic logic model_tmo(input in_t x);
        return m_wait && (m_waited == TO - 1) && !x.dram_ready;
    endfunction

    // which rule governs this cycle: 0 none, 1 DRAM stall, 2 redirect, 3 load-use
    function automatic int model_win(input in_t x);
        logic lu;
        lu = x.ex_is_load && x.ex_rf_we && (x.ex_wR != 0) &&
             ((x.id_rs1_used && x.id_rs1 == x.ex_wR) || (x.id_rs2_used && x.id_rs2 == x.ex_wR));
        if (x.mem_req && !x.dram_ready && !model_tmo(x)) return 1;
        if (x.ex_redirect) return 2;
        if (lu) return 3;
        return 0;
    endfunction

    function automatic logic [1:0] fwd_of(input logic [4:0] rs, input in_t x);
        logic [4:0] dst  [2];
        logic       we   [2];
        logic [1:0] code [2];
        dst[0] = x.mem_wR; we[0] = x.mem_rf_we; code[0] = 2'b01;
        dst[1] = x.wb_wR;  we[1] = x.wb_rf_we;  code[1] = 2'b10;
        for (int i = 0; i < 2; i++) begin
            if (we[i] && dst[i] != 0 && dst[i] == rs) return code[i];
        end
        return 2'b00;
    endfunction

    function automatic logic [12:0] model_ctrl(input in_t x);
        logic [7:0] c;
        case (model_win(x))
            1:       c = 8'b00001_001;
            2:       c = 8'b11111_110;
            3:       c = 8'b00111_010;
            default: c = 8'b11111_000;
        endcase
        return {x.mem_req, c, fwd_of(x.ex_rs1, x), fwd_of(x.ex_rs2, x)};
    endfunction

    task automatic model_update(input in_t x);
        int   w;
        logic t;
        w = model_win(x);
        t = model_tmo(x);
        if (w == 1 || w == 3) m_stall = (m_stall >= MAXC) ? MAXC : m_stall + 1;
        if (w == 2)           m_flush = (m_flush >= MAXC) ? MAXC : m_flush + 1;
        if (t) m_err = 1'b1;
        if (!m_wait) begin
            m_wait   = x.mem_req && !x.dram_ready;
            m_waited = 0;
        end else if (x.dram_ready || t) begin
            m_wait = 1'b0;
        end else begin
            m_waited++;
        end
    endtask

    task automatic model_reset();
        m_wait = 0; m_waited = 0; m_stall = 0; m_flush = 0; m_err = 0;
    endtask

    // One clock: compare at the falling edge, advance the model at the rising edge.
    // exp_pc < 0 means no directed pc_en expectation for this cycle.
    task automatic cycle(input string tag, input logic use_exp, input logic [12:0] exp, input int exp_pc);
        apply();
        @(negedge clk);
        check({tag, "_ctrl"}, 64'(dut_ctrl), 64'(model_ctrl(cur)));
        if (use_exp) check({tag, "_tbl"}, 64'(dut_ctrl), 64'(exp));
        if (exp_pc >= 0) check({tag, "_pc_en"}, 64'(bus.pc_en), 64'(exp_pc));
        check({tag, "_stall_cnt"}, 64'(bus.stall_cnt), 64'(m_stall));
        check({tag, "_flush_cnt"}, 64'(bus.flush_cnt), 64'(m_flush));
        check({tag, "_tmo_err"},   64'(bus.timeout_err), 64'(m_err));
        @(posedge clk);
        model_update(cur);
        #1;
    endtask

    function automatic in_t rand_in();
        in_t r;
        r.id_rs1      = 5'($urandom_range(0, 3));
        r.id_rs2      = 5'($urandom_range(0, 3));
        r.id_rs1_used = 1'($urandom);
        r.id_rs2_used = 1'($urandom);
        r.ex_rs1      = 5'($urandom_range(0, 3));
        r.ex_rs2      = 5'($urandom_range(0, 3));
        r.ex_wR       = 5'($urandom_range(0, 3));
        r.ex_rf_we    = 1'($urandom);
        r.ex_is_load  = 1'($urandom);
        r.mem_wR      = 5'($urandom_range(0, 3));
        r.mem_rf_we   = 1'($urandom);
        r.wb_wR       = 5'($urandom_range(0, 3));
        r.wb_rf_we    = 1'($urandom);
        r.ex_redirect = ($urandom_range(0, 4) == 0);
        r.mem_req     = ($urandom_range(0, 3) == 0);
        r.dram_ready  = ($urandom_range(0, 2) == 0);
        return r;
    endfunction

    // Entered at posedge+1; asserts reset mid-cycle, returns at posedge+1.
    task automatic do_reset(input string tag);
        #2 rst = 1'b0;
        model_reset();
        #1;
        check({tag, "_async_stall"}, 64'(bus.stall_cnt), 64'(0));
        check({tag, "_async_flush"}, 64'(bus.flush_cnt), 64'(0));
        check({tag, "_async_err"},   64'(bus.timeout_err), 64'(0));
        for (int i = 0; i < 3; i++) begin
            cur = rand_in();
            apply();
            @(negedge clk);
            check({tag, "_hold_cnt"}, 64'({bus.stall_cnt, bus.flush_cnt, bus.timeout_err}), 64'(0));
            @(posedge clk);
        end
        cur = '0;
        apply();
        @(negedge clk);
        check({tag, "_idle_ctrl"}, 64'(dut_ctrl), 64'(ALL_RUN));
        @(posedge clk);
        #1 rst = 1'b1;
    endtask

    vec_t tbl [10];

    initial begin
        rst = 1'b0;
        cur = '0;
        apply();
        model_reset();
        repeat (2) @(posedge clk);
        #1;

        tbl[0] = '{"zero",      in_t'(0), ALL_RUN};
        tbl[1] = '{"load_use",  '{ex_is_load:1'b1, ex_rf_we:1'b1, ex_wR:5'd5, id_rs2:5'd5,
                                  id_rs2_used:1'b1, default:'0}, 13'b0_00111_010_00_00};
        tbl[2] = '{"lu_x0",     '{ex_is_load:1'b1, ex_rf_we:1'b1, ex_wR:5'd0, id_rs2:5'd0,
                                  id_rs2_used:1'b1, default:'0}, ALL_RUN};
        tbl[3] = '{"redir_lu",  '{ex_is_load:1'b1, ex_rf_we:1'b1, ex_wR:5'd5, id_rs2:5'd5,
                                  id_rs2_used:1'b1, ex_redirect:1'b1, default:'0}, 13'b0_11111_110_00_00};
        tbl[4] = '{"fwd_mem",   '{mem_wR:5'd7, wb_wR:5'd7, ex_rs1:5'd7, ex_rs2:5'd7, mem_rf_we:1'b1,
                                  wb_rf_we:1'b1, default:'0}, 13'b0_11111_000_01_01};
        tbl[5] = '{"fwd_wb",    '{mem_wR:5'd7, wb_wR:5'd7, ex_rs1:5'd7, mem_rf_we:1'b0,
                                  wb_rf_we:1'b1, default:'0}, 13'b0_11111_000_10_00};
        tbl[6] = '{"fwd_x0",    '{mem_wR:5'd7, wb_wR:5'd7, ex_rs1:5'd0, mem_rf_we:1'b1,
                                  wb_rf_we:1'b1, default:'0}, ALL_RUN};
        tbl[7] = '{"dram_0w",   '{mem_req:1'b1, dram_ready:1'b1, default:'0}, 13'b1_11111_000_00_00};
        tbl[8] = '{"dram_stall",'{mem_req:1'b1, ex_redirect:1'b1, default:'0}, 13'b1_00001_001_00_00};
        tbl[9] = '{"dram_done", '{mem_req:1'b1, dram_ready:1'b1, default:'0}, 13'b1_11111_000_00_00};

        do_reset("rst0");

        for (int i = 0; i < 10; i++) begin
            cur = tbl[i].in;
            cycle(tbl[i].name, 1'b1, tbl[i].exp, -1);
        end
        check("tbl_stall_cnt", 64'(bus.stall_cnt), 64'(2));
        check("tbl_flush_cnt", 64'(bus.flush_cnt), 64'(1));

        // DRAM wait of three cycles, released by dram_ready on the fourth
        cur = '0; cur.mem_req = 1'b1;
        for (int i = 0; i < 3; i++) cycle("dram_wait", 1'b1, 13'b1_00001_001_00_00, 0);
        cur.dram_ready = 1'b1;
        cycle("dram_rel", 1'b1, 13'b1_11111_000_00_00, 1);
        check("dram_stall_cnt", 64'(bus.stall_cnt), 64'(5));

        // Timeout: dram_ready never rises
        cur = '0; cur.mem_req = 1'b1;
        for (int i = 0; i < 4; i++) cycle("to_wait", 1'b0, '0, 0);
        cycle("to_release", 1'b0, '0, 1);
        check("to_err", 64'(bus.timeout_err), 64'(1));
        check("to_stall_cnt", 64'(bus.stall_cnt), 64'(9));
        cur = '0;
        for (int i = 0; i < 3; i++) begin
            cycle("to_idle", 1'b0, '0, 1);
            check("to_sticky", 64'(bus.timeout_err), 64'(1));
        end

        // Reset in the middle of a DRAM wait
        cur = '0; cur.mem_req = 1'b1;
        cycle("mid_enter", 1'b0, '0, 0);
        do_reset("rst_mid");
        cur = '0; cur.mem_req = 1'b1;
        for (int i = 0; i < 4; i++) cycle("post_rst_wait", 1'b0, '0, 0);
        cur.dram_ready = 1'b1;
        cycle("post_rst_rel", 1'b0, '0, 1);
        check("post_rst_err", 64'(bus.timeout_err), 64'(0));

        // Counter saturation
        do_reset("rst_sat");
        cur = '0; cur.ex_redirect = 1'b1;
        for (int i = 0; i < 260; i++) cycle("sat", 1'b0, '0, 1);
        check("sat_flush_cnt", 64'(bus.flush_cnt), 64'(MAXC));

        // Randomized run against the model
        do_reset("rst_rand");
        for (int i = 0; i < 3000; i++) begin
            cur = rand_in();
            if (m_wait) cur.mem_req = 1'b1;
            if (i == 1500 && !m_wait) begin
                cycle("rand", 1'b0, '0, -1);
                do_reset("rst_rand2");
            end else begin
                cycle("rand", 1'b0, '0, -1);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
